// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC-1 load, per-round C/D rotation, PC-2 subkeys over valid/ready.
// Optional DES_KEY_SCHEDULE_DECRYPT_EN adds a decrypt input that emits K16..K1 using right rotations.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key_in,
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
    input  logic        decrypt,
`endif
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam int PC1_TAB [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // DES numbers bits from the MSB, so DES bit n lives at key[64-n] and PC-1 bit 1 lands at [55].
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++)
            r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++)
            r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
        return r;
    endfunction

    function automatic logic shift_two(input logic [3:0] r);
        return !(r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state, state_n;
    logic [27:0] c, d, c_n, d_n;
    logic [3:0]  round_n;
    logic        done_n;
    logic [55:0] pc1_key;
    logic        rev;
    logic        load_rev;

    assign pc1_key = pc1(key_in);

`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
    logic dec_q;

    assign rev      = dec_q;
    assign load_rev = decrypt;

    // Direction is latched with the key so a later change of decrypt cannot disturb a running schedule.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dec_q <= 1'b0;
        else if (state == IDLE && start)
            dec_q <= decrypt;
    end
`else
    assign rev      = 1'b0;
    assign load_rev = 1'b0;
`endif

    always_comb begin
        state_n = state;
        c_n     = c;
        d_n     = d;
        round_n = round;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = EMIT;
                    if (load_rev) begin
                        c_n     = pc1_key[55:28];
                        d_n     = pc1_key[27:0];
                        round_n = 4'd15;
                    end else begin
                        c_n     = rotl(pc1_key[55:28], 1'b0);
                        d_n     = rotl(pc1_key[27:0], 1'b0);
                        round_n = 4'd0;
                    end
                end
            end
            EMIT: begin
                if (subkey_ready) begin
                    if (!rev) begin
                        if (round == 4'd15) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            c_n     = rotl(c, shift_two(4'(round + 4'd1)));
                            d_n     = rotl(d, shift_two(4'(round + 4'd1)));
                            round_n = round + 4'd1;
                        end
                    end else begin
                        // Undo the shift that produced the current subkey to step back one round.
                        if (round == 4'd0) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            c_n     = rotr(c, shift_two(round));
                            d_n     = rotr(d, shift_two(round));
                            round_n = round - 4'd1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            c     <= '0;
            d     <= '0;
            round <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            c     <= c_n;
            d     <= d_n;
            round <= round_n;
            done  <= done_n;
        end
    end

    assign subkey_valid = (state == EMIT);
    assign busy         = (state == EMIT);
    assign subkey       = pc2({c, d});

endmodule
